// File: rtl/hammer_pkg.sv
// Shared types and helpers for the hammer sprite controller: swing states, sprite ids,
// control-word field values, and saturating move / overlap arithmetic on 11-bit coordinates.
package hammer_pkg;

   localparam int COORD_W = 11;
   localparam int CTRL_W  = 5;

   typedef enum logic [2:0] {
      IDLE,
      RAISE,
      STRIKE,
      RECOVER,
      COOLDOWN
   } state_t;

   localparam logic [1:0] SID_REST    = 2'd0;
   localparam logic [1:0] SID_RAISE   = 2'd1;
   localparam logic [1:0] SID_STRIKE  = 2'd2;
   localparam logic [1:0] SID_RECOVER = 2'd3;

   localparam logic [1:0] CTRL_COLOR = 2'b00;
   localparam logic       CTRL_AUTO  = 1'b0;

   function automatic logic [1:0] state_sid(input state_t s);
      case (s)
         RAISE:   return SID_RAISE;
         STRIKE:  return SID_STRIKE;
         RECOVER: return SID_RECOVER;
         default: return SID_REST;
      endcase
   endfunction

   // Opposing buttons cancel; result saturates to [0, lim] rather than wrapping.
   function automatic logic [COORD_W-1:0] step_clamp(input logic [COORD_W-1:0] pos,
                                                     input logic dec,
                                                     input logic inc,
                                                     input logic [COORD_W-1:0] step,
                                                     input logic [COORD_W-1:0] lim);
      logic signed [COORD_W:0] nxt;
      nxt = $signed({1'b0, pos});
      if (dec && !inc)
         nxt = nxt - $signed({1'b0, step});
      else if (inc && !dec)
         nxt = nxt + $signed({1'b0, step});
      if (nxt < 0)
         return '0;
      else if (nxt > $signed({1'b0, lim}))
         return lim;
      else
         return nxt[COORD_W-1:0];
   endfunction

   function automatic logic near(input logic [COORD_W-1:0] a,
                                 input logic [COORD_W-1:0] b,
                                 input logic [COORD_W-1:0] size);
      logic signed [COORD_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d < 0)
         d = -d;
      return d < $signed({1'b0, size});
   endfunction

endpackage

// File: rtl/hammer_ctrl_if.sv
// Bundle between the hammer controller and its surroundings: scan position, buttons,
// rat target in; sprite origin, control word and strike result out.
interface hammer_ctrl_if;
   import hammer_pkg::*;

   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               btn_up;
   logic               btn_down;
   logic               btn_left;
   logic               btn_right;
   logic               btn_hit;
   logic [COORD_W-1:0] tgt_x0;
   logic [COORD_W-1:0] tgt_y0;
   logic               tgt_valid;
   logic [COORD_W-1:0] x0;
   logic [COORD_W-1:0] y0;
   logic [CTRL_W-1:0]  ctrl;
   logic               hit_pulse;
   logic               hit_success;
   logic               busy;

   modport master (
      output x, y, btn_up, btn_down, btn_left, btn_right, btn_hit,
             tgt_x0, tgt_y0, tgt_valid,
      input  x0, y0, ctrl, hit_pulse, hit_success, busy
   );

   modport slave (
      input  x, y, btn_up, btn_down, btn_left, btn_right, btn_hit,
             tgt_x0, tgt_y0, tgt_valid,
      output x0, y0, ctrl, hit_pulse, hit_success, busy
   );

endinterface

// File: rtl/hammer_frame_tick.sv
// One-clk frame strobe on arrival at scan origin (0,0); combinational from x/y plus one
// registered copy, so a slow pixel rate holding (0,0) for many clks still gives one tick.
module hammer_frame_tick
   import hammer_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic               frame_tick
);

   logic [COORD_W-1:0] x_d1;
   logic [COORD_W-1:0] y_d1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_d1 <= '0;
         y_d1 <= '0;
      end else begin
         x_d1 <= x;
         y_d1 <= y;
      end
   end

   assign frame_tick = (x == '0) && (y == '0) && !((x_d1 == '0) && (y_d1 == '0));

endmodule

// File: rtl/hammer_ctrl.sv
// Hammer control: buttons -> sprite origin/ctrl, frame-paced swing FSM with one-clk hit strobe.
// HAMMER_HIT_QUEUE_EN queues one hit request made during a swing until the swing completes.
module hammer_ctrl
   import hammer_pkg::*;
#(
   parameter int H_MAX        = 640,
   parameter int V_MAX        = 480,
   parameter int SPR_SIZE     = 16,
   parameter int STEP         = 2,
   parameter int PHASE_FRAMES = 4,
   parameter int COOL_FRAMES  = 8,
   parameter int X0_INIT      = 312,
   parameter int Y0_INIT      = 232
)(
   input  logic         clk,
   input  logic         reset_n,
   hammer_ctrl_if.slave bus
);

   localparam int FC_MAX = (PHASE_FRAMES > COOL_FRAMES) ? PHASE_FRAMES : COOL_FRAMES;
   localparam int FC_W   = $clog2(FC_MAX + 1);

   localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(H_MAX - SPR_SIZE);
   localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(V_MAX - SPR_SIZE);
   localparam logic [COORD_W-1:0] STEP_V = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] SIZE_V = COORD_W'(SPR_SIZE);
   localparam logic [COORD_W-1:0] X_INIT = COORD_W'(X0_INIT);
   localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(Y0_INIT);
   localparam logic [FC_W-1:0]    PH_LAST = FC_W'(PHASE_FRAMES - 1);
   localparam logic [FC_W-1:0]    CL_LAST = FC_W'(COOL_FRAMES - 1);

   state_t             state, state_nxt;
   logic [FC_W-1:0]    fc, fc_nxt;
   logic               tick;
   logic               btn_hit_d1;
   logic               hit_edge;
   logic               req;
   logic               strike_enter;
   logic               move_en;
   logic               cool_done;
   logic [COORD_W-1:0] x0_r, y0_r;
   logic [CTRL_W-1:0]  ctrl_r;
   logic               hit_pulse_r, hit_success_r;

   hammer_frame_tick u_frame_tick (
      .clk        (clk),
      .reset_n    (reset_n),
      .x          (bus.x),
      .y          (bus.y),
      .frame_tick (tick)
   );

   always_comb begin
      state_nxt = state;
      fc_nxt    = fc;
      if (tick) begin
         case (state)
            IDLE: if (req) begin
               state_nxt = RAISE;
               fc_nxt    = '0;
            end
            RAISE: if (fc == PH_LAST) begin
               state_nxt = STRIKE;
               fc_nxt    = '0;
            end else fc_nxt = fc + 1'b1;
            STRIKE: begin
               state_nxt = RECOVER;
               fc_nxt    = '0;
            end
            RECOVER: if (fc == PH_LAST) begin
               state_nxt = COOLDOWN;
               fc_nxt    = '0;
            end else fc_nxt = fc + 1'b1;
            COOLDOWN: if (fc == CL_LAST) begin
               state_nxt = IDLE;
               fc_nxt    = '0;
            end else fc_nxt = fc + 1'b1;
            default: begin
               state_nxt = IDLE;
               fc_nxt    = '0;
            end
         endcase
      end
   end

   assign hit_edge     = bus.btn_hit && !btn_hit_d1;
   assign strike_enter = (state == RAISE) && (state_nxt == STRIKE);
   assign move_en      = tick && ((state == IDLE) || (state == COOLDOWN));
   assign cool_done    = (state == COOLDOWN) && (state_nxt == IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         fc            <= '0;
         ctrl_r        <= '0;
         btn_hit_d1    <= 1'b0;
         hit_pulse_r   <= 1'b0;
         hit_success_r <= 1'b0;
         x0_r          <= X_INIT;
         y0_r          <= Y_INIT;
      end else begin
         state         <= state_nxt;
         fc            <= fc_nxt;
         ctrl_r        <= {CTRL_COLOR, CTRL_AUTO, state_sid(state_nxt)};
         btn_hit_d1    <= bus.btn_hit;
         hit_pulse_r   <= strike_enter;
         // x0/y0 are frozen here, so the registered result matches the strike frame's origin.
         hit_success_r <= strike_enter && bus.tgt_valid &&
                          near(x0_r, bus.tgt_x0, SIZE_V) && near(y0_r, bus.tgt_y0, SIZE_V);
         if (move_en) begin
            x0_r <= step_clamp(x0_r, bus.btn_left, bus.btn_right, STEP_V, X_LIM);
            y0_r <= step_clamp(y0_r, bus.btn_up, bus.btn_down, STEP_V, Y_LIM);
         end
      end
   end

`ifdef HAMMER_HIT_QUEUE_EN
   logic queued;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req    <= 1'b0;
         queued <= 1'b0;
      end else begin
         if (cool_done) begin
            req    <= queued || hit_edge;
            queued <= 1'b0;
         end else begin
            if (state == IDLE && state_nxt == RAISE)
               req <= 1'b0;
            else if (hit_edge && state == IDLE)
               req <= 1'b1;
            if (hit_edge && state != IDLE)
               queued <= 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         req <= 1'b0;
      else if (state == IDLE && state_nxt == RAISE)
         req <= 1'b0;
      else if (hit_edge && state == IDLE)
         req <= 1'b1;
   end

   logic unused_cool_done;
   assign unused_cool_done = cool_done;
`endif

   assign bus.x0          = x0_r;
   assign bus.y0          = y0_r;
   assign bus.ctrl        = ctrl_r;
   assign bus.hit_pulse   = hit_pulse_r;
   assign bus.hit_success = hit_success_r;
   assign bus.busy        = (state == RAISE) || (state == STRIKE) || (state == RECOVER);

endmodule

// File: tb/tb_hammer_ctrl.sv
// Directed bench for hammer_ctrl: movement/clamping, swing timing, strike overlap, reset mid-swing.
// Frames are compressed: the scan sits at (7,3) and visits (0,0) for one clk per frame.
module tb_hammer_ctrl;
   import hammer_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   int   pulse_cnt = 0;
   logic last_succ = 1'b0;
   logic stray_succ = 1'b0;

   always #5 clk = ~clk;

   hammer_ctrl_if hif();

   hammer_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (hif)
   );

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (hif.hit_pulse === 1'b1) begin
            pulse_cnt++;
            last_succ = hif.hit_success;
         end else if (hif.hit_success !== 1'b0) begin
            stray_succ = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic frame();
      @(negedge clk);
      hif.x = 11'd0;
      hif.y = 11'd0;
      @(negedge clk);
      hif.x = 11'd7;
      hif.y = 11'd3;
      @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic do_reset();
      hif.btn_up = 1'b0; hif.btn_down = 1'b0; hif.btn_left = 1'b0; hif.btn_right = 1'b0;
      hif.btn_hit = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic press_hit();
      hif.btn_hit = 1'b1;
      @(negedge clk);
      @(negedge clk);
      hif.btn_hit = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_tgt(input int tx, input int ty, input logic v);
      hif.tgt_x0    = 11'(tx);
      hif.tgt_y0    = 11'(ty);
      hif.tgt_valid = v;
   endtask

   task automatic swing(input string tag, input logic exp_succ);
      int p0;
      p0 = pulse_cnt;
      press_hit();
      frames(18);
      chk({tag, "_pulses"}, 32'(pulse_cnt - p0), 1);
      chk({tag, "_succ"}, {31'd0, last_succ}, {31'd0, exp_succ});
   endtask

   initial begin
      int p0;
      int exp_sid, exp_busy, exp_y;
      reset_n = 1'b0;
      hif.x = 11'd7; hif.y = 11'd3;
      hif.btn_up = 1'b0; hif.btn_down = 1'b0; hif.btn_left = 1'b0; hif.btn_right = 1'b0;
      hif.btn_hit = 1'b0;
      set_tgt(320, 240, 1'b1);
      do_reset();

      chk("rst_x0", hif.x0, 312);
      chk("rst_y0", hif.y0, 232);
      chk("rst_ctrl", hif.ctrl, 0);
      chk("rst_busy", hif.busy, 0);
      chk("rst_pulse", hif.hit_pulse, 0);
      chk("rst_succ", hif.hit_success, 0);

      hif.btn_right = 1'b1;
      frames(10);
      hif.btn_right = 1'b0;
      chk("right10_x0", hif.x0, 332);
      chk("right10_y0", hif.y0, 232);
      chk("right10_ctrl", hif.ctrl, 0);
      chk("right10_busy", hif.busy, 0);

      do_reset();
      hif.btn_left = 1'b1;
      frames(200);
      chk("left_sat_x0", hif.x0, 0);
      hif.btn_right = 1'b1;
      frames(3);
      chk("lr_cancel_x0", hif.x0, 0);
      hif.btn_left = 1'b0; hif.btn_right = 1'b0;
      hif.btn_down = 1'b1;
      frames(200);
      chk("down_sat_y0", hif.y0, 464);
      hif.btn_up = 1'b1;
      frames(2);
      chk("ud_cancel_y0", hif.y0, 464);
      hif.btn_up = 1'b0; hif.btn_down = 1'b0;
      hif.btn_right = 1'b1;
      frames(320);
      hif.btn_right = 1'b0;
      chk("right_sat_x0", hif.x0, 624);

      // Full swing with up held across the busy phases: origin must not move until COOLDOWN.
      do_reset();
      set_tgt(320, 240, 1'b1);
      p0 = pulse_cnt;
      press_hit();
      for (int k = 1; k <= 18; k++) begin
         hif.btn_up = (k >= 2 && k <= 12);
         frame();
         exp_sid  = (k <= 4) ? 1 : (k == 5) ? 2 : (k <= 9) ? 3 : 0;
         exp_busy = (k <= 9) ? 1 : 0;
         exp_y    = (k <= 10) ? 232 : (k == 11) ? 230 : 228;
         chk($sformatf("swing_sid_f%0d", k), hif.ctrl, exp_sid);
         chk($sformatf("swing_busy_f%0d", k), hif.busy, exp_busy);
         chk($sformatf("swing_y0_f%0d", k), hif.y0, exp_y);
      end
      hif.btn_up = 1'b0;
      chk("swing_pulses", 32'(pulse_cnt - p0), 1);
      chk("swing_succ", {31'd0, last_succ}, 1);
      chk("swing_x0", hif.x0, 312);

      do_reset();
      set_tgt(328, 232, 1'b1);
      swing("miss_dx16", 1'b0);
      set_tgt(296, 232, 1'b1);
      swing("miss_dxm16", 1'b0);
      set_tgt(312, 232, 1'b0);
      swing("miss_invalid", 1'b0);
      set_tgt(327, 247, 1'b1);
      swing("hit_edge15", 1'b1);
      set_tgt(297, 217, 1'b1);
      swing("hit_edgem15", 1'b1);

      // Second hit edge while raising.
      set_tgt(320, 240, 1'b1);
      p0 = pulse_cnt;
      press_hit();
      frame();
      chk("dbl_raise_sid", hif.ctrl, 1);
      press_hit();
      frames(17);
      chk("dbl_pulses", 32'(pulse_cnt - p0), 1);
      chk("dbl_idle_sid", hif.ctrl, 0);
      frame();
`ifdef HAMMER_HIT_QUEUE_EN
      chk("dbl_next_sid", hif.ctrl, 1);
      chk("dbl_next_busy", hif.busy, 1);
`else
      chk("dbl_next_sid", hif.ctrl, 0);
      chk("dbl_next_busy", hif.busy, 0);
`endif

      // Reset mid-RECOVER.
      do_reset();
      hif.btn_left = 1'b1;
      frames(106);
      hif.btn_left = 1'b0;
      chk("pre_x0", hif.x0, 100);
      press_hit();
      frames(7);
      chk("rec_sid", hif.ctrl, 3);
      chk("rec_busy", hif.busy, 1);
      chk("rec_x0", hif.x0, 100);
      p0 = pulse_cnt;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_x0", hif.x0, 312);
      chk("arst_y0", hif.y0, 232);
      chk("arst_ctrl", hif.ctrl, 0);
      chk("arst_busy", hif.busy, 0);
      chk("arst_pulse", hif.hit_pulse, 0);
      @(negedge clk);
      reset_n = 1'b1;
      frames(20);
      chk("post_rst_pulses", 32'(pulse_cnt - p0), 0);
      chk("post_rst_ctrl", hif.ctrl, 0);
      chk("post_rst_busy", hif.busy, 0);

      chk("stray_succ", {31'd0, stray_succ}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hammer_ctrl.md
Name: hammer_ctrl

Overview:
- Upstream control stage for the hammer sprite source.
- Converts player buttons into the hammer sprite origin (x0, y0) and the 5-bit sprite control word (sprite id for the swing animation).
- Runs a frame-paced swing FSM and reports a one-cycle hit strobe with overlap result against the rat's origin.
- Outputs connect directly to the sprite source's x0/y0/ctrl inputs; hit outputs go to the score logic.

Parameters:
H_MAX, 640, visible width in pixels
V_MAX, 480, visible height in pixels
SPR_SIZE, 16, hammer and rat sprite edge length in pixels
STEP, 2, pixels moved per frame per held direction
PHASE_FRAMES, 4, frames spent in RAISE and in RECOVER
COOL_FRAMES, 8, frames of COOLDOWN after RECOVER
X0_INIT, 312, reset x origin
Y0_INIT, 232, reset y origin

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
x  in  11  current scan x coordinate
y  in  11  current scan y coordinate
btn_up, btn_down, btn_left, btn_right  in  1 each  synchronized, debounced level inputs
btn_hit  in  1  synchronized, debounced level input
tgt_x0  in  11  rat origin x
tgt_y0  in  11  rat origin y
tgt_valid  in  1  rat currently visible
x0  out  11  hammer origin x
y0  out  11  hammer origin y
ctrl  out  5  sprite control: [4:3] color, fixed 2'b00; [2] auto, fixed 0; [1:0] sprite id
hit_pulse  out  1  one-cycle strike strobe
hit_success  out  1  valid with hit_pulse: overlap and tgt_valid
busy  out  1  high in RAISE, STRIKE, RECOVER

Behaviour:
- Clock and reset: one clock domain (clk). reset_n is asynchronous, active-low.
- Reset values: x0=X0_INIT, y0=Y0_INIT, ctrl=0, hit_pulse=0, hit_success=0, busy=0, state=IDLE, all counters 0, hit-edge register 0.
- frame_tick:
  - Registered x_d1/y_d1.
  - tick = (x==0 && y==0) && !(x_d1==0 && y_d1==0).
  - Exactly one clk per frame, even when the pixel rate is slower than clk.
- Hit request:
  - Rising edge of btn_hit (registered previous value) sets req when state==IDLE.
  - Edges in any other state are dropped.
  - req clears on entering RAISE.
- FSM (all transitions on frame_tick only):
  - IDLE (sid 0): if req, go to RAISE and set frame counter fc=0.
  - RAISE (sid 1): fc increments each tick. After PHASE_FRAMES ticks, go to STRIKE.
  - STRIKE (sid 2): lasts one frame.
    - On the entry clk, hit_pulse=1 for exactly that one clk.
    - On the same clk, hit_success = tgt_valid && |x0-tgt_x0|<SPR_SIZE && |y0-tgt_y0|<SPR_SIZE.
    - Differences use 12-bit signed arithmetic; equality at SPR_SIZE is a miss.
    - hit_success is 0 whenever hit_pulse is 0.
    - Next tick: go to RECOVER.
  - RECOVER (sid 3): after PHASE_FRAMES ticks, go to COOLDOWN.
  - COOLDOWN (sid 0): after COOL_FRAMES ticks, go to IDLE.
- ctrl[1:0] tracks the state's sid registered, updated on the same clk as the state register.
- Movement:
  - Applies only in IDLE and COOLDOWN, on frame_tick.
  - left-only: x0 -= STEP. right-only: x0 += STEP. Both or neither: x unchanged. y is handled the same way with up/down.
  - Clamp x0 to [0, H_MAX-SPR_SIZE] and y0 to [0, V_MAX-SPR_SIZE]. Compute in 12-bit signed, saturate, never wrap.
  - x0 and y0 are frozen during RAISE, STRIKE, and RECOVER.
- Reset asserted mid-swing: immediate return to reset values; no hit_pulse is emitted.
- Latency: button level to x0 change ≤1 frame + 1 clk.

Optional Feature:
- Macro: HAMMER_HIT_QUEUE_EN.
- Defined:
  - A btn_hit rising edge during RAISE, STRIKE, RECOVER, or COOLDOWN sets a 1-deep queued flag; further edges are ignored while it is set.
  - On the COOLDOWN→IDLE tick the flag transfers to req and clears, so the next swing starts one tick later.
  - Reset clears the flag.
- Undefined: edges outside IDLE are dropped, as in the baseline.

Decomposition:
- Package hammer_pkg holds:
  - State enum: IDLE, RAISE, STRIKE, RECOVER, COOLDOWN.
  - Sid constants: SID_REST=0, SID_RAISE=1, SID_STRIKE=2, SID_RECOVER=3.
  - CTRL width (5) and the fixed color and auto field values.
- One sub-module, hammer_frame_tick: registers x/y and generates the one-clk frame_tick. It is shared with future sprite controllers.

Test Plan:
- Reset, then hold btn_right for 10 frames → x0=332, y0=232, ctrl=0, busy=0.
- Hold btn_left for 200 frames from reset → x0 saturates at 0, no wrap. Hold btn_down long → y0 saturates at 464.
- Pulse btn_hit with tgt=(320,240), tgt_valid=1, hammer at (312,232) → sid sequence 0→1 (4 frames)→2 (1 frame)→3 (4 frames)→0 (8 frames). Exactly one hit_pulse, with hit_success=1.
- Strike with tgt=(328,232) (|dx|=16) → hit_pulse=1, hit_success=0. Repeat with tgt_valid=0 and tgt equal to the hammer origin → hit_success=0.
- Second btn_hit edge during RAISE → no second swing (baseline). With HAMMER_HIT_QUEUE_EN defined → a second RAISE begins on the tick after COOLDOWN ends.
- Assert reset_n=0 during RECOVER with x0=100 → x0=312, state IDLE, ctrl=0 asynchronously, no hit_pulse afterward.
